// File: rtl/ma_pkg.sv
// Shared types and width helpers for the multi-channel fixed-point moving averager.
package ma_pkg;

    typedef enum logic [0:0] {
        StClear = 1'b0,
        StRun   = 1'b1
    } state_t;

    // A running sum of 2**log2_len samples never needs more than log2_len growth bits.
    function automatic int unsigned sum_width(input int unsigned data_w,
                                              input int unsigned log2_len);
        return data_w + log2_len;
    endfunction

    function automatic int unsigned round_const(input int unsigned log2_len,
                                                input int unsigned round);
        return (round != 0) ? (32'd1 << (log2_len - 1)) : 32'd0;
    endfunction

endpackage

// File: rtl/ma_hist_ram.sv
// Simple dual-port sample history RAM: one write, one synchronous read, write-first bypass.
module ma_hist_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ma_fixed_mc.sv
// Multi-channel moving average over 2**LOG2_LEN samples; channels share one stream and one
// history RAM, with per-channel running sum, write pointer and fill count.
module ma_fixed_mc
    import ma_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned LOG2_LEN = 2,
    parameter int unsigned N_CH     = 4,
    parameter int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int unsigned ROUND    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_ch,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_full
);

    localparam int unsigned LEN    = 1 << LOG2_LEN;
    localparam int unsigned SUM_W  = sum_width(DATA_W, LOG2_LEN);
    localparam int unsigned ADDR_W = CH_W + LOG2_LEN;
    localparam int unsigned DEPTH  = N_CH * LEN;

    localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CH_W:0]       CH_LIM    = (CH_W + 1)'(N_CH);
    localparam logic [LOG2_LEN:0]   FILL_MAX  = (LOG2_LEN + 1)'(LEN);
    localparam logic signed [SUM_W:0] RND     = (SUM_W + 1)'(round_const(LOG2_LEN, ROUND));

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic              clearing;

    logic signed [SUM_W-1:0] sum_q  [N_CH];
    logic [LOG2_LEN-1:0]     wptr_q [N_CH];
    logic [LOG2_LEN:0]       fill_q [N_CH];

    logic                     a_valid_q;
    logic signed [DATA_W-1:0] a_data_q;
    logic [CH_W-1:0]          a_ch_q;

    logic                out_valid_q, out_full_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [CH_W-1:0]     out_ch_q;

    logic                    ch_ok, accept;
    logic [CH_W-1:0]         rd_ch;
    logic [LOG2_LEN-1:0]     rd_wptr, b_wptr;
    logic [DATA_W-1:0]       ram_rdata;
    logic signed [SUM_W-1:0] new_sum;
    logic signed [SUM_W:0]   rnd_sum;
    logic [LOG2_LEN:0]       new_fill;
    logic [DATA_W-1:0]       avg;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [DATA_W-1:0] ram_wdata;

    assign clearing = (state_q == StClear);
    assign in_ready = (state_q == StRun);
    assign ch_ok    = ({1'b0, in_ch} < CH_LIM);
    assign accept   = in_valid & in_ready & ch_ok & ~clr;

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            StClear: begin
                if (sweep_q == LAST_ADDR) begin
                    state_d = StRun;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StClear;
        endcase
        if (clr) begin
            state_d = StClear;
            sweep_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StClear;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // The update stage writes its channel's pointer at the same edge the next read issues,
    // so a same-channel follow-on must see the advanced pointer.
    assign b_wptr  = wptr_q[a_ch_q];
    assign rd_ch   = ch_ok ? in_ch : '0;
    assign rd_wptr = (a_valid_q && (a_ch_q == in_ch)) ? b_wptr + 1'b1 : wptr_q[rd_ch];

    assign new_sum  = sum_q[a_ch_q] - SUM_W'($signed(ram_rdata)) + SUM_W'(a_data_q);
    assign rnd_sum  = (SUM_W + 1)'(new_sum) + RND;
    assign avg      = DATA_W'(rnd_sum >>> LOG2_LEN);
    assign new_fill = (fill_q[a_ch_q] == FILL_MAX) ? FILL_MAX : fill_q[a_ch_q] + 1'b1;

    assign ram_we    = clearing | a_valid_q;
    assign ram_waddr = clearing ? sweep_q : {a_ch_q, b_wptr};
    assign ram_wdata = clearing ? '0 : a_data_q;
    assign ram_raddr = {rd_ch, rd_wptr};

    ma_hist_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_hist (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_q <= 1'b0;
            a_data_q  <= '0;
            a_ch_q    <= '0;
        end else begin
            a_valid_q <= accept;
            if (accept) begin
                a_data_q <= in_data;
                a_ch_q   <= in_ch;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                sum_q[i]  <= '0;
                wptr_q[i] <= '0;
                fill_q[i] <= '0;
            end
        end else if (clearing) begin
            for (int i = 0; i < N_CH; i++) begin
                sum_q[i]  <= '0;
                wptr_q[i] <= '0;
                fill_q[i] <= '0;
            end
        end else if (a_valid_q) begin
            sum_q[a_ch_q]  <= new_sum;
            wptr_q[a_ch_q] <= b_wptr + 1'b1;
            fill_q[a_ch_q] <= new_fill;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_full_q  <= 1'b0;
        end else begin
            out_valid_q <= a_valid_q;
            if (a_valid_q) begin
                out_data_q <= avg;
                out_ch_q   <= a_ch_q;
                out_full_q <= (new_fill == FILL_MAX);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_full  = out_full_q;

endmodule

// File: tb/tb_ma_fixed_mc.sv
// Directed bench: floor and round-half-up instances driven in lockstep, checked against
// hand-computed window averages.
module tb_ma_fixed_mc;

    localparam int DATA_W = 16;
    localparam int CH_W   = 2;

    typedef struct {
        int ch;
        int d0;
        int d1;
        int full;
        int cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n, clr, in_valid;
    logic [DATA_W-1:0] in_data;
    logic [CH_W-1:0]   in_ch;

    logic              in_ready0, out_valid0, out_full0;
    logic [DATA_W-1:0] out_data0;
    logic [CH_W-1:0]   out_ch0;
    logic              in_ready1, out_valid1, out_full1;
    logic [DATA_W-1:0] out_data1;
    logic [CH_W-1:0]   out_ch1;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    exp_t e;

    ma_fixed_mc #(.DATA_W(DATA_W), .LOG2_LEN(2), .N_CH(4), .CH_W(CH_W), .ROUND(0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .in_data   (in_data),
        .in_ch     (in_ch),
        .out_valid (out_valid0),
        .out_data  (out_data0),
        .out_ch    (out_ch0),
        .out_full  (out_full0)
    );

    ma_fixed_mc #(.DATA_W(DATA_W), .LOG2_LEN(2), .N_CH(4), .CH_W(CH_W), .ROUND(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_data   (in_data),
        .in_ch     (in_ch),
        .out_valid (out_valid1),
        .out_data  (out_data1),
        .out_ch    (out_ch1),
        .out_full  (out_full1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid0 || out_valid1) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", int'(out_valid0 | out_valid1), 0);
            end else begin
                e = exp_q.pop_front();
                check("valid0", int'(out_valid0), 1);
                check("valid1", int'(out_valid1), 1);
                check("ch0", int'(out_ch0), e.ch);
                check("ch1", int'(out_ch1), e.ch);
                check("data_floor", int'($signed(out_data0)), e.d0);
                check("data_round", int'($signed(out_data1)), e.d1);
                check("full0", int'(out_full0), e.full);
                check("full1", int'(out_full1), e.full);
                check("latency", cyc, e.cyc);
            end
        end
    end

    task automatic send(input int ch, input int data, input int d0, input int d1,
                        input int full);
        in_valid = 1'b1;
        in_ch    = CH_W'(ch);
        in_data  = DATA_W'(data);
        exp_q.push_back('{ch, d0, d1, full, cyc + 2});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_clear(input bit outs_zero);
        int n = 0;
        while (!in_ready0 && n < 100) begin
            if (outs_zero) begin
                check("clr_outs0", int'({out_valid0, out_full0, out_ch0, out_data0}), 0);
                check("clr_outs1", int'({out_valid1, out_full1, out_ch1, out_data1}), 0);
            end
            check("clr_ready1", int'(in_ready1), 0);
            @(posedge clk);
            #1;
            n++;
        end
        check("clear_len", n, 16);
        check("ready1", int'(in_ready1), 1);
    endtask

    // A sample presented together with clr must be dropped.
    task automatic do_clear();
        in_valid = 1'b1;
        in_ch    = '0;
        in_data  = 16'd999;
        clr      = 1'b1;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        wait_clear(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r0p[6] = '{8191, 16383, 24575, 32767, 32767, 32767};
        int r1p[6] = '{8192, 16384, 24575, 32767, 32767, 32767};
        int rn[6]  = '{-8192, -16384, -24576, -32768, -32768, -32768};

        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_ch    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs0", int'({in_ready0, out_valid0, out_full0, out_ch0, out_data0}), 0);
        check("rst_outs1", int'({in_ready1, out_valid1, out_full1, out_ch1, out_data1}), 0);
        rst_n = 1'b1;
        wait_clear(1'b1);

        // Back-to-back on one channel through warm-up into a full window.
        send(0, 4, 1, 1, 0);
        send(0, 8, 3, 3, 0);
        send(0, 12, 6, 6, 0);
        send(0, 16, 10, 10, 1);
        send(0, 20, 14, 14, 1);
        idle(4);

        send(1, 6, 1, 2, 0);
        send(2, -1, -1, 0, 0);
        idle(4);

        do_clear();
        for (int i = 0; i < 4; i++) begin
            send(0, 100, 25 * (i + 1), 25 * (i + 1), int'(i == 3));
            send(3, -100, -25 * (i + 1), -25 * (i + 1), int'(i == 3));
        end
        idle(4);

        do_clear();
        for (int i = 0; i < 6; i++) send(0, 32767, r0p[i], r1p[i], int'(i >= 3));
        for (int i = 0; i < 6; i++) send(1, -32768, rn[i], rn[i], int'(i >= 3));
        idle(4);

        do_clear();
        send(0, 8, 2, 2, 0);
        idle(4);

        // Reset asserted while a result is one cycle from emerging.
        in_valid = 1'b1;
        in_ch    = 2'd1;
        in_data  = 16'd40;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_kill0", int'(out_valid0), 0);
            check("rst_kill1", int'(out_valid1), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_clear(1'b1);

        check("exp_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ma_fixed_mc.md
Name: ma_fixed_mc

Overview:
- Multi-channel, fixed-point moving-average filter over a power-of-two window.
- Replaces the single-channel real-valued averager in the DSP chain ahead of detection/decimation.
- Channels are time-multiplexed on one valid/ready stream, one sample per cycle sustained.
- Each channel keeps its own sample history, running sum and fill count in shared RAM.

Parameters:
- DATA_W, 16, signed two's-complement sample width.
- LOG2_LEN, 2, log2 of window length; LEN = 2**LOG2_LEN; range 1..8.
- N_CH, 4, number of independent channels; range 1..64.
- CH_W, $clog2(N_CH) min 1, channel index width.
- ROUND, 1, 1 = round half up (add 2**(LOG2_LEN-1) before shift); 0 = floor (arithmetic shift only).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous pulse; restarts the history clear sweep.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  signed input sample.
- in_ch  in  CH_W  channel of in_data; values >= N_CH are ignored.
- out_valid  out  1  one-cycle result strobe, no backpressure.
- out_data  out  DATA_W  signed window average.
- out_ch  out  CH_W  channel of out_data.
- out_full  out  1  channel has received >= LEN samples since the last clear.

Behaviour:
- Reset (rst_n low, any time): all outputs 0, state = ST_CLEAR, sweep index 0, pipeline valids 0. Work in flight is dropped.
- FSM ST_CLEAR:
  - Writes zero to one history entry per cycle over N_CH*LEN entries.
  - Zeroes each channel's sum, write pointer and fill count.
  - in_ready = 0 throughout.
  - After the last entry, go to ST_RUN.
  - Duration N_CH*LEN cycles.
- FSM ST_RUN: in_ready = 1.
  - clr = 1 in ST_RUN or ST_CLEAR sends the FSM to ST_CLEAR with sweep index 0.
  - Any sample accepted in the same cycle as clr is discarded.
  - In-pipeline results still emit.
- Accept = in_valid & in_ready & (in_ch < N_CH).
  - Samples with in_ch >= N_CH are consumed and produce no output.
- Pipeline, latency 2:
  - Cycle A: register sample/channel; read oldest = hist[ch][wptr[ch]], sum[ch], fill[ch].
  - Cycle B:
    - new_sum = sum - oldest + sample, width DATA_W+LOG2_LEN, so it never overflows.
    - Write hist[ch][wptr] = sample, wptr += 1 modulo LEN, fill = min(fill+1, LEN).
    - Register the result.
  - out_valid asserts 2 cycles after accept.
  - out_data = (new_sum + (ROUND ? 2**(LOG2_LEN-1) : 0)) >>> LOG2_LEN, truncated to DATA_W. This always fits.
  - The rounding add is done at sum width + 1.
- Warm-up: missing history counts as zero, so the output is the sum over LEN. out_full = (updated fill == LEN).
- Hazard: back-to-back accepts on the same channel must produce results identical to spaced accepts.
  - Cycle B forwards new_sum, wptr and fill to cycle A.
  - The history read must also see a write to the same address made in the same cycle.
- Any channel interleaving is legal; per-channel state is fully independent.

Decomposition:
- Package ma_pkg:
  - state encoding ST_CLEAR/ST_RUN.
  - function for sum width (DATA_W+LOG2_LEN).
  - rounding constant helper.
- One sub-module: ma_hist_ram. Simple dual-port, one write, one read, depth N_CH*LEN, width DATA_W, synchronous read, write-first bypass.
- Top holds the FSM, per-channel sum/wptr/fill registers, forwarding logic and output stage.

Test Plan:
- Reset released, LEN=4, N_CH=4 → in_ready low exactly 16 cycles, then high; all outputs 0 during that time.
- ch0 inputs 4,8,12,16,20 back-to-back, ROUND=0 → out_data 1,3,6,10,14; out_full 0,0,0,1,1; each result 2 cycles after its accept.
- ROUND=1, ch1 single input 6 → 2; input -1 on fresh ch2 → 0. Same with ROUND=0 → 1 and -1.
- Interleave ch0=100, ch3=-100 alternating 8 samples → ch0 outputs 25,50,75,100,...; ch3 outputs -25,-50,-75,-100; out_ch matches.
- Full-scale: ch0 fed 32767 ×6 → 32767 at steady state. ch1 fed -32768 ×6 → -32768. No wrap.
- clr pulse after ch0 reaches out_full, then 16 clear cycles, then input 8 → out_data 2, out_full 0. Separately, rst_n low mid-stream kills a pending out_valid.
